multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle MIPS main controller: sequences shared ALU/memory/regfile datapath per instruction phase (fetch,
//  decode, execute, mem, writeback). Drives datapath muxes/enables; waits on memory handshake; flags bad opcodes.
//  Sits beside the ALU control decoder, consumes IR[31:26] from the instruction register.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles a memory state waits for MemReady before aborting (>=1)
//  TO_W          5  width of timeout counter; must hold MEM_TIMEOUT
// PORTS
//  Clk          in   1  clock, all state changes on rising edge
//  Reset_n      in   1  synchronous, active-low reset
//  Opcode       in   6  IR[31:26], stable from DECODE until instruction end
//  MemReady     in   1  memory completes current read/write this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if branch condition true
//  BranchNe     out  1  1: condition is !Zero (BNE), 0: Zero (BEQ)
//  IorD         out  1  memory address: 0 PC, 1 ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  load instruction register
//  MemtoReg     out  1  regfile write data: 0 ALUOut, 1 MDR
//  RegDst       out  1  dest reg: 0 rt, 1 rd
//  RegWrite     out  1  regfile write enable
//  ALUSrcA      out  1  0 PC, 1 rs
//  ALUSrcB      out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  PCSource     out  2  00 ALU result, 01 ALUOut, 10 jump target
//  ALUOp        out  4  0000 add, 0001 sub, 0010 funct, 0100 addi, 0101 addiu, 0110 andi, 0111 ori, 1000 xori,
//                       1001 slti, 1010 sltiu
//  IllegalOp    out  1  one-cycle pulse: unsupported opcode
//  MemTimeout   out  1  one-cycle pulse: memory state aborted
//  State        out  4  current state code (debug)
// BEHAVIOUR
//  States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP.
//  Reset_n low at an edge -> state RST, timeout counter 0; RST drives every output 0 (State=0); next edge -> FETCH.
//  Reset mid-instruction aborts at once: no further write/PC update; partial memory access dropped.
//  Outputs Moore from state; only IRWrite/PCWrite in FETCH and RegWrite in MEMWB qualified by MemReady. Unlisted=0.
//  FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0000, PCSource=00; IRWrite=PCWrite=MemReady;
//   MemReady -> DECODE, else stay.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=0000 (branch target to ALUOut). Dispatch: 000000->REXEC;
//   100011/101011->MEMADR; 000100/000101->BRANCH; 000010->JUMP; 001000..001110 except 001111,
//   plus 001010/001011 ->IEXEC; 110110 (NOP)->FETCH; else IllegalOp=1, ->FETCH.
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=0000; LW->MEMRD, SW->MEMWR.
//  MEMRD: MemRead, IorD=1; MemReady -> MEMWB. MEMWB: MemtoReg=1, RegDst=0, RegWrite -> FETCH.
//  MEMWR: MemWrite, IorD=1; MemReady -> FETCH.
//  REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=0010 -> RWB. RWB: RegDst=1, RegWrite, MemtoReg=0 -> FETCH.
//  IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode table above -> IWB. IWB: RegDst=0, RegWrite -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0001, PCWriteCond, PCSource=01, BranchNe=(Opcode==000101) -> FETCH.
//  JUMP: PCWrite, PCSource=10 -> FETCH.
//  CPI: R/imm 4, branch/jump 3, SW 4, LW 5 with zero-wait memory; each wait cycle adds one.
//  Timeout: counter clears on entering FETCH/MEMRD/MEMWR, increments each cycle there without MemReady;
//   at MEM_TIMEOUT without MemReady -> MemTimeout=1 that cycle, ->FETCH, no IR/PC/reg/mem update.
//   MemReady on the same cycle the count hits MEM_TIMEOUT wins (normal completion).
//  MemReady in a non-memory state is ignored. MemRead and MemWrite never both 1.
// STRUCTURE
//  Shared package/header: opcode defines, ALUOp codes, state encodings, ALUSrcB/PCSource mux codes.
//  Sub-module: mem_wait_timer (counter + compare, clear/enable/expired) instantiated once.
// TESTING
//  Reset_n=0 two edges then 1, MemReady=1 -> outputs all 0 in RST, State=FETCH next cycle, IRWrite=PCWrite=1.
//  Opcode=100011, MemReady=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite+MemtoReg=1 only in cycle 5.
//  Opcode=000101, MemReady=1 -> BRANCH: PCWriteCond=1, BranchNe=1, ALUOp=0001, PCSource=01; back to FETCH.
//  Opcode=101011, MemReady low 20 cycles in MEMWR -> MemTimeout pulse after 16 waits, FETCH, MemWrite drops.
//  Opcode=111111 -> IllegalOp one-cycle pulse in DECODE, no RegWrite/MemWrite/PCWrite, next state FETCH.
//  Opcode=001101, Reset_n low during IEXEC -> IWB never reached, RegWrite stays 0, RST then FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller.
// Contents: state encodings, opcode values, ALUOp codes, ALUSrcB/PCSource mux
// selects, and the DECODE helpers (dispatch target, legality, I-type ALUOp).
package multicycle_control_fsm_pkg;

    // The encoding is visible on the State debug port, so it is fixed explicitly.
    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_REXEC  = 4'd7,
        ST_RWB    = 4'd8,
        ST_IEXEC  = 4'd9,
        ST_IWB    = 4'd10,
        ST_BRANCH = 4'd11,
        ST_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_NOP   = 6'b110110;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_ADDI  = 4'b0100;
    localparam logic [3:0] ALU_ADDIU = 4'b0101;
    localparam logic [3:0] ALU_ANDI  = 4'b0110;
    localparam logic [3:0] ALU_ORI   = 4'b0111;
    localparam logic [3:0] ALU_XORI  = 4'b1000;
    localparam logic [3:0] ALU_SLTI  = 4'b1001;
    localparam logic [3:0] ALU_SLTIU = 4'b1010;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // LUI (001111) sits inside the I-type opcode range but is not supported.
    function automatic logic is_imm_op(input logic [5:0] op);
        return op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI};
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return is_imm_op(op) ||
               (op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_NOP});
    endfunction

    // Illegal opcodes and NOP both fall back to FETCH.
    function automatic state_t dispatch(input logic [5:0] op);
        if (op == OP_RTYPE)                return ST_REXEC;
        else if (op inside {OP_LW, OP_SW}) return ST_MEMADR;
        else if (op inside {OP_BEQ, OP_BNE}) return ST_BRANCH;
        else if (op == OP_J)               return ST_JUMP;
        else if (is_imm_op(op))            return ST_IEXEC;
        else                               return ST_FETCH;
    endfunction

    function automatic logic [3:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ADDI:  return ALU_ADDI;
            OP_ADDIU: return ALU_ADDIU;
            OP_ANDI:  return ALU_ANDI;
            OP_ORI:   return ALU_ORI;
            OP_XORI:  return ALU_XORI;
            OP_SLTI:  return ALU_SLTI;
            OP_SLTIU: return ALU_SLTIU;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Wait-cycle counter for the controller's memory states.
// Ports: clk, rst_n (synchronous, active-low), clear (restart count at 0,
// has priority), enable (count one wait cycle), expired (count == LIMIT).
module multicycle_control_fsm_mem_wait_timer #(
    parameter int LIMIT = 16,
    parameter int W     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)      count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 1'b1;
    end

    assign expired = (count == W'(LIMIT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main controller. Steps the shared datapath through
// fetch/decode/execute/memory/writeback, waits on MemReady, aborts memory
// states after MEM_TIMEOUT wait cycles and flags unsupported opcodes.
// Inputs:  Clk, Reset_n (synchronous, active-low), Opcode (IR[31:26]), MemReady.
// Outputs: PC/IR/regfile/memory strobes, datapath mux selects, ALUOp,
//          IllegalOp and MemTimeout pulses, State (debug state code).
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic       IllegalOp,
    output logic       MemTimeout,
    output logic [3:0] State
);

    state_t state, next_state;
    logic   in_mem_state, expired, timed_out;

    assign in_mem_state = state inside {ST_FETCH, ST_MEMRD, ST_MEMWR};
    // MemReady on the expiry cycle counts as normal completion.
    assign timed_out    = in_mem_state && expired && !MemReady;

    // Restarting on every state change (and on a FETCH->FETCH abort) gives
    // each memory state a fresh wait budget.
    multicycle_control_fsm_mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT),
        .W     (TO_W)
    ) u_mem_wait_timer (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .clear   ((next_state != state) || timed_out),
        .enable  (in_mem_state && !MemReady),
        .expired (expired)
    );

    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        next_state = state;
        case (state)
            ST_RST:    next_state = ST_FETCH;
            ST_FETCH:  if (MemReady) next_state = ST_DECODE;
            ST_DECODE: next_state = dispatch(Opcode);
            ST_MEMADR: next_state = (Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (MemReady) next_state = ST_MEMWB;
                       else if (timed_out) next_state = ST_FETCH;
            ST_MEMWB:  next_state = ST_FETCH;
            ST_MEMWR:  if (MemReady || timed_out) next_state = ST_FETCH;
            ST_REXEC:  next_state = ST_RWB;
            ST_RWB:    next_state = ST_FETCH;
            ST_IEXEC:  next_state = ST_IWB;
            ST_IWB:    next_state = ST_FETCH;
            ST_BRANCH: next_state = ST_FETCH;
            ST_JUMP:   next_state = ST_FETCH;
            default:   next_state = ST_RST;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= ST_RST;
        else          state <= next_state;
    end

    // Moore decode; only the FETCH IR/PC loads and the MEMWB register write
    // look at MemReady.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALU_ADD;
        IllegalOp   = 1'b0;
        case (state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            ST_DECODE: begin
                ALUSrcB   = SRCB_IMM_SH;
                IllegalOp = !is_legal_op(Opcode);
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = MemReady;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            ST_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = imm_aluop(Opcode);
            end
            ST_IWB:   RegWrite = 1'b1;
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNe    = (Opcode == OP_BNE);
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
        // A reset landing mid-instruction must not let the edge that enters
        // RST also commit a write, PC load or memory access.
        if (!Reset_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign MemTimeout = timed_out;
    assign State      = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Expected output vectors are built
// from per-state tables, queued when a step is driven, and popped and compared
// on the following falling edge.
module tb_multicycle_control_fsm;

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5,
                           S_MEMWR = 4'd6, S_REXEC = 4'd7, S_RWB = 4'd8,
                           S_IEXEC = 4'd9, S_IWB = 4'd10, S_BRANCH = 4'd11,
                           S_JUMP = 4'd12;

    typedef struct packed {
        logic [3:0] state;
        logic       pcwrite, pcwritecond, branchne, iord, memread, memwrite;
        logic       irwrite, memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb, pcsource;
        logic [3:0] aluop;
        logic       illegalop, memtimeout;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       memready = 1'b1;
    logic       pcwrite, pcwritecond, branchne, iord, memread, memwrite;
    logic       irwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluop, state;
    logic       illegalop, memtimeout;
    obs_t       obs;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .Clk(clk), .Reset_n(reset_n), .Opcode(opcode), .MemReady(memready),
        .PCWrite(pcwrite), .PCWriteCond(pcwritecond), .BranchNe(branchne),
        .IorD(iord), .MemRead(memread), .MemWrite(memwrite), .IRWrite(irwrite),
        .MemtoReg(memtoreg), .RegDst(regdst), .RegWrite(regwrite),
        .ALUSrcA(alusrca), .ALUSrcB(alusrcb), .PCSource(pcsource), .ALUOp(aluop),
        .IllegalOp(illegalop), .MemTimeout(memtimeout), .State(state)
    );

    assign obs = '{state: state, pcwrite: pcwrite, pcwritecond: pcwritecond,
                   branchne: branchne, iord: iord, memread: memread,
                   memwrite: memwrite, irwrite: irwrite, memtoreg: memtoreg,
                   regdst: regdst, regwrite: regwrite, alusrca: alusrca,
                   alusrcb: alusrcb, pcsource: pcsource, aluop: aluop,
                   illegalop: illegalop, memtimeout: memtimeout};

    function automatic obs_t ex_base(input logic [3:0] s);
        obs_t e = '0;
        e.state = s;
        return e;
    endfunction

    function automatic obs_t ex_fetch(input logic rdy, input logic to);
        obs_t e = ex_base(S_FETCH);
        e.memread = 1'b1; e.alusrcb = 2'b01;
        e.irwrite = rdy;  e.pcwrite = rdy; e.memtimeout = to;
        return e;
    endfunction

    function automatic obs_t ex_decode(input logic ill);
        obs_t e = ex_base(S_DECODE);
        e.alusrcb = 2'b11; e.illegalop = ill;
        return e;
    endfunction

    function automatic obs_t ex_memadr();
        obs_t e = ex_base(S_MEMADR);
        e.alusrca = 1'b1; e.alusrcb = 2'b10;
        return e;
    endfunction

    function automatic obs_t ex_memrd(input logic to);
        obs_t e = ex_base(S_MEMRD);
        e.memread = 1'b1; e.iord = 1'b1; e.memtimeout = to;
        return e;
    endfunction

    function automatic obs_t ex_memwb(input logic rdy);
        obs_t e = ex_base(S_MEMWB);
        e.memtoreg = 1'b1; e.regwrite = rdy;
        return e;
    endfunction

    function automatic obs_t ex_memwr(input logic to);
        obs_t e = ex_base(S_MEMWR);
        e.memwrite = 1'b1; e.iord = 1'b1; e.memtimeout = to;
        return e;
    endfunction

    function automatic obs_t ex_rexec();
        obs_t e = ex_base(S_REXEC);
        e.alusrca = 1'b1; e.aluop = 4'b0010;
        return e;
    endfunction

    function automatic obs_t ex_rwb();
        obs_t e = ex_base(S_RWB);
        e.regdst = 1'b1; e.regwrite = 1'b1;
        return e;
    endfunction

    function automatic obs_t ex_iexec(input logic [3:0] op);
        obs_t e = ex_base(S_IEXEC);
        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = op;
        return e;
    endfunction

    function automatic obs_t ex_iwb();
        obs_t e = ex_base(S_IWB);
        e.regwrite = 1'b1;
        return e;
    endfunction

    function automatic obs_t ex_branch(input logic ne);
        obs_t e = ex_base(S_BRANCH);
        e.alusrca = 1'b1; e.aluop = 4'b0001; e.pcwritecond = 1'b1;
        e.pcsource = 2'b01; e.branchne = ne;
        return e;
    endfunction

    function automatic obs_t ex_jump();
        obs_t e = ex_base(S_JUMP);
        e.pcwrite = 1'b1; e.pcsource = 2'b10;
        return e;
    endfunction

    // One clock cycle: drive inputs just after the rising edge, queue the
    // expected outputs for this cycle, compare on the falling edge.
    task automatic step(input logic rst, input logic rdy, input logic [5:0] op,
                        input obs_t exp, input string tag);
        obs_t  e;
        string t;
        reset_n  = rst;
        memready = rdy;
        opcode   = op;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset held, then released: RST shows all-zero outputs, FETCH follows.
        step(1'b0, 1'b1, 6'b000000, ex_base(S_RST), "rst_low");
        step(1'b1, 1'b1, 6'b000000, ex_base(S_RST), "rst_release");

        // LW, zero-wait memory: five cycles, register write only in MEMWB.
        step(1'b1, 1'b1, 6'b100011, ex_fetch(1'b1, 1'b0), "lw_fetch");
        step(1'b1, 1'b1, 6'b100011, ex_decode(1'b0), "lw_decode");
        step(1'b1, 1'b1, 6'b100011, ex_memadr(), "lw_memadr");
        step(1'b1, 1'b1, 6'b100011, ex_memrd(1'b0), "lw_memrd");
        step(1'b1, 1'b1, 6'b100011, ex_memwb(1'b1), "lw_memwb");

        // BNE then BEQ.
        step(1'b1, 1'b1, 6'b000101, ex_fetch(1'b1, 1'b0), "bne_fetch");
        step(1'b1, 1'b1, 6'b000101, ex_decode(1'b0), "bne_decode");
        step(1'b1, 1'b1, 6'b000101, ex_branch(1'b1), "bne_branch");
        step(1'b1, 1'b1, 6'b000100, ex_fetch(1'b1, 1'b0), "beq_fetch");
        step(1'b1, 1'b1, 6'b000100, ex_decode(1'b0), "beq_decode");
        step(1'b1, 1'b1, 6'b000100, ex_branch(1'b0), "beq_branch");

        // R-type, with one FETCH wait cycle first.
        step(1'b1, 1'b0, 6'b000000, ex_fetch(1'b0, 1'b0), "r_fetch_wait");
        step(1'b1, 1'b1, 6'b000000, ex_fetch(1'b1, 1'b0), "r_fetch");
        step(1'b1, 1'b1, 6'b000000, ex_decode(1'b0), "r_decode");
        step(1'b1, 1'b1, 6'b000000, ex_rexec(), "r_exec");
        step(1'b1, 1'b1, 6'b000000, ex_rwb(), "r_wb");

        // Jump, then ADDI and XORI ALUOp codes.
        step(1'b1, 1'b1, 6'b000010, ex_fetch(1'b1, 1'b0), "j_fetch");
        step(1'b1, 1'b1, 6'b000010, ex_decode(1'b0), "j_decode");
        step(1'b1, 1'b1, 6'b000010, ex_jump(), "j_jump");
        step(1'b1, 1'b1, 6'b001000, ex_fetch(1'b1, 1'b0), "addi_fetch");
        step(1'b1, 1'b1, 6'b001000, ex_decode(1'b0), "addi_decode");
        step(1'b1, 1'b1, 6'b001000, ex_iexec(4'b0100), "addi_exec");
        step(1'b1, 1'b1, 6'b001000, ex_iwb(), "addi_wb");
        step(1'b1, 1'b1, 6'b001110, ex_fetch(1'b1, 1'b0), "xori_fetch");
        step(1'b1, 1'b1, 6'b001110, ex_decode(1'b0), "xori_decode");
        step(1'b1, 1'b1, 6'b001110, ex_iexec(4'b1000), "xori_exec");
        step(1'b1, 1'b1, 6'b001110, ex_iwb(), "xori_wb");

        // SW with MemReady low: 16 plain waits, abort pulse on the 17th cycle.
        step(1'b1, 1'b1, 6'b101011, ex_fetch(1'b1, 1'b0), "swto_fetch");
        step(1'b1, 1'b1, 6'b101011, ex_decode(1'b0), "swto_decode");
        step(1'b1, 1'b0, 6'b101011, ex_memadr(), "swto_memadr");
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, 6'b101011, ex_memwr(1'b0), $sformatf("swto_wait%0d", i));
        step(1'b1, 1'b0, 6'b101011, ex_memwr(1'b1), "swto_abort");
        // Back in FETCH with a fresh wait budget.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 6'b101011, ex_fetch(1'b0, 1'b0), $sformatf("swto_fetch_wait%0d", i));

        // SW zero-wait: four cycles.
        step(1'b1, 1'b1, 6'b101011, ex_fetch(1'b1, 1'b0), "sw_fetch");
        step(1'b1, 1'b1, 6'b101011, ex_decode(1'b0), "sw_decode");
        step(1'b1, 1'b1, 6'b101011, ex_memadr(), "sw_memadr");
        step(1'b1, 1'b1, 6'b101011, ex_memwr(1'b0), "sw_memwr");

        // LW whose MemReady arrives exactly as the count reaches the limit.
        step(1'b1, 1'b1, 6'b100011, ex_fetch(1'b1, 1'b0), "lwedge_fetch");
        step(1'b1, 1'b1, 6'b100011, ex_decode(1'b0), "lwedge_decode");
        step(1'b1, 1'b1, 6'b100011, ex_memadr(), "lwedge_memadr");
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, 6'b100011, ex_memrd(1'b0), $sformatf("lwedge_wait%0d", i));
        step(1'b1, 1'b1, 6'b100011, ex_memrd(1'b0), "lwedge_ready");
        step(1'b1, 1'b1, 6'b100011, ex_memwb(1'b1), "lwedge_memwb");

        // Illegal opcodes, LUI included, and NOP.
        step(1'b1, 1'b1, 6'b111111, ex_fetch(1'b1, 1'b0), "ill_fetch");
        step(1'b1, 1'b1, 6'b111111, ex_decode(1'b1), "ill_decode");
        step(1'b1, 1'b1, 6'b001111, ex_fetch(1'b1, 1'b0), "lui_fetch");
        step(1'b1, 1'b1, 6'b001111, ex_decode(1'b1), "lui_decode");
        step(1'b1, 1'b1, 6'b110110, ex_fetch(1'b1, 1'b0), "nop_fetch");
        step(1'b1, 1'b1, 6'b110110, ex_decode(1'b0), "nop_decode");

        // ORI aborted by reset during IEXEC.
        step(1'b1, 1'b1, 6'b001101, ex_fetch(1'b1, 1'b0), "orirst_fetch");
        step(1'b1, 1'b1, 6'b001101, ex_decode(1'b0), "orirst_decode");
        step(1'b0, 1'b1, 6'b001101, ex_iexec(4'b0111), "orirst_iexec");
        step(1'b1, 1'b1, 6'b001101, ex_base(S_RST), "orirst_rst");
        step(1'b1, 1'b1, 6'b001101, ex_fetch(1'b1, 1'b0), "orirst_refetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
